// File: rtl/temporizador_regressivo.sv
// BCD countdown timer, 00:00 to 59:99 (seconds:hundredths).
// Loadable preset, pause/resume, one-cycle done pulse and timed blinking alarm.
module temporizador_regressivo #(
    parameter int ALARM_HALF_PERIOD = 25,
    parameter int ALARM_DURATION    = 300
) (
    input  logic       clk_100hz,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_s_dezena,
    input  logic [3:0] preset_s_unidade,
    input  logic [3:0] preset_cs_dezena,
    input  logic [3:0] preset_cs_unidade,
    output logic [3:0] s_dezena,
    output logic [3:0] s_unidade,
    output logic [3:0] cs_dezena,
    output logic [3:0] cs_unidade,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int HW = (ALARM_HALF_PERIOD > 1) ? $clog2(ALARM_HALF_PERIOD) : 1;
    localparam int DW = (ALARM_DURATION > 1) ? $clog2(ALARM_DURATION) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(ALARM_HALF_PERIOD - 1);
    localparam logic [DW-1:0] DUR_LAST  = DW'(ALARM_DURATION - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } state_t;

    state_t state_q, state_d;

    logic [3:0] sd_q, sd_d;
    logic [3:0] su_q, su_d;
    logic [3:0] cd_q, cd_d;
    logic [3:0] cu_q, cu_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;
    logic [HW-1:0] half_q, half_d;
    logic [DW-1:0] dur_q, dur_d;

    logic [3:0] p_sd, p_su, p_cd, p_cu;
    logic [3:0] dec_sd, dec_su, dec_cd, dec_cu;
    logic       b0, b1, b2;
    logic       cnt_zero, dec_zero;
    logic       go, hold, ack;

    // Clamp preset digits into the displayable range.
    always_comb begin
        p_sd = (preset_s_dezena   > 4'd5) ? 4'd5 : preset_s_dezena;
        p_su = (preset_s_unidade  > 4'd9) ? 4'd9 : preset_s_unidade;
        p_cd = (preset_cs_dezena  > 4'd9) ? 4'd9 : preset_cs_dezena;
        p_cu = (preset_cs_unidade > 4'd9) ? 4'd9 : preset_cs_unidade;
    end

    // One-step BCD decrement with the borrow chain; never wraps below 00:00.
    always_comb begin
        b0     = (cu_q == 4'd0);
        dec_cu = b0 ? 4'd9 : cu_q - 4'd1;
        b1     = b0 && (cd_q == 4'd0);
        dec_cd = b0 ? ((cd_q == 4'd0) ? 4'd9 : cd_q - 4'd1) : cd_q;
        b2     = b1 && (su_q == 4'd0);
        dec_su = b1 ? ((su_q == 4'd0) ? 4'd9 : su_q - 4'd1) : su_q;
        dec_sd = (b2 && sd_q != 4'd0) ? sd_q - 4'd1 : sd_q;
        cnt_zero = ({sd_q, su_q, cd_q, cu_q} == 16'd0);
        dec_zero = ({dec_sd, dec_su, dec_cd, dec_cu} == 16'd0);
    end

    // Next-state logic: load dominates, start+pause together cancel out.
    always_comb begin
        go      = start & ~pause;
        hold    = pause & ~start;
        ack     = start ^ pause;
        state_d = state_q;
        sd_d    = sd_q;
        su_d    = su_q;
        cd_d    = cd_q;
        cu_d    = cu_q;
        done_d  = 1'b0;
        alarm_d = alarm_q;
        half_d  = half_q;
        dur_d   = dur_q;
        if (load) begin
            sd_d    = p_sd;
            su_d    = p_su;
            cd_d    = p_cd;
            cu_d    = p_cu;
            state_d = IDLE;
            alarm_d = 1'b0;
            half_d  = '0;
            dur_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go && !cnt_zero) state_d = RUNNING;
                end
                RUNNING: begin
                    if (hold) begin
                        state_d = PAUSED;
                    end else begin
                        sd_d = dec_sd;
                        su_d = dec_su;
                        cd_d = dec_cd;
                        cu_d = dec_cu;
                        if (dec_zero) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                            alarm_d = 1'b1;
                            half_d  = '0;
                            dur_d   = '0;
                        end
                    end
                end
                PAUSED: begin
                    if (go) state_d = RUNNING;
                end
                EXPIRED: begin
                    if (ack || dur_q == DUR_LAST) begin
                        state_d = IDLE;
                        alarm_d = 1'b0;
                        half_d  = '0;
                        dur_d   = '0;
                    end else begin
                        dur_d = dur_q + 1'b1;
                        if (half_q == HALF_LAST) begin
                            half_d  = '0;
                            alarm_d = ~alarm_q;
                        end else begin
                            half_d = half_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUNNING);
    end

    // State, count, flags and alarm timers; async active-low clear.
    always_ff @(posedge clk_100hz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sd_q      <= 4'd0;
            su_q      <= 4'd0;
            cd_q      <= 4'd0;
            cu_q      <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            half_q    <= '0;
            dur_q     <= '0;
        end else begin
            state_q   <= state_d;
            sd_q      <= sd_d;
            su_q      <= su_d;
            cd_q      <= cd_d;
            cu_q      <= cu_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
            half_q    <= half_d;
            dur_q     <= dur_d;
        end
    end

    assign s_dezena   = sd_q;
    assign s_unidade  = su_q;
    assign cs_dezena  = cd_q;
    assign cs_unidade = cu_q;
    assign running    = running_q;
    assign done       = done_q;
    assign alarm      = alarm_q;

endmodule

// File: doc/temporizador_regressivo.md
Name: temporizador_regressivo

Overview:
- BCD countdown timer, the down-counting counterpart of the stopwatch counter. Range is 00:00 to 59:99 (seconds:hundredths).
- Loads a BCD preset from the switch/keypad logic. Counts down at 100 Hz and signals expiry with a one-cycle done pulse and a timed blinking alarm.
- Outputs feed the same 7-segment decoders as the stopwatch (HEX3..HEX0).

Parameters:
- ALARM_HALF_PERIOD, 25: clk_100hz cycles per alarm blink half-period (0.25 s).
- ALARM_DURATION, 300: clk_100hz cycles the alarm stays active after expiry (3 s).

Ports:
- clk_100hz  input  1  100 Hz tick clock from the clock divider
- reset  input  1  asynchronous, active-low; clears all state
- load  input  1  one-cycle pulse; captures the preset digits
- start  input  1  one-cycle pulse; begins or resumes the countdown
- pause  input  1  one-cycle pulse; freezes the countdown
- preset_s_dezena  input  4  preset seconds tens, BCD
- preset_s_unidade  input  4  preset seconds units, BCD
- preset_cs_dezena  input  4  preset hundredths tens, BCD
- preset_cs_unidade  input  4  preset hundredths units, BCD
- s_dezena  output  4  current seconds tens (HEX3)
- s_unidade  output  4  current seconds units (HEX2)
- cs_dezena  output  4  current hundredths tens (HEX1)
- cs_unidade  output  4  current hundredths units (HEX0)
- running  output  1  high while in RUNNING
- done  output  1  one-cycle pulse on expiry
- alarm  output  1  blinking alarm drive (LED/buzzer)

Behaviour:
- Reset is asynchronous, active-low; clock is clk_100hz. Reset values: all digits 0, running=0, done=0, alarm=0, state IDLE, alarm counters 0. Reset asserted mid-count or mid-alarm aborts immediately to these values.
- load/start/pause are synchronous, already debounced and edge-detected single-cycle pulses.
- States: IDLE, RUNNING, PAUSED, EXPIRED. running = (state == RUNNING), registered.
- Preset capture on load, registered, visible the cycle after the load edge:
  - Any unit or hundredths-tens digit > 9 is clamped to 9.
  - preset_s_dezena > 5 is clamped to 5.
- Priority in every state: load > (start, pause). start and pause high together: no effect. load while RUNNING or PAUSED: capture the preset and go to IDLE.
- IDLE:
  - start with count != 00:00 -> RUNNING. The first decrement occurs on the next clock edge after the start edge.
  - start with count == 00:00 -> ignored.
  - pause -> ignored.
- RUNNING: each clk_100hz edge decrements the 4-digit BCD count with borrow chain:
  - cs_unidade 0 -> 9 borrows from cs_dezena.
  - cs_dezena 0 -> 9 borrows from s_unidade.
  - s_unidade 0 -> 9 borrows from s_dezena.
  - Digits never leave the BCD range.
  - pause -> PAUSED; the count holds the value present at the pause edge (no decrement on that edge).
  - start -> ignored.
- Expiry: on the edge where the count goes 00:01 -> 00:00:
  - state becomes EXPIRED.
  - done=1 for exactly that following cycle.
  - alarm=1, alarm counters restart.
  - The count never underflows; it stays at 00:00.
- PAUSED:
  - start -> RUNNING, resuming from the held value.
  - pause -> ignored.
  - load -> IDLE with the new preset.
- EXPIRED:
  - alarm toggles every ALARM_HALF_PERIOD cycles, starting high.
  - After ALARM_DURATION cycles, go to IDLE with alarm=0.
  - start or pause during EXPIRED acknowledges: IDLE, alarm=0 on the next cycle.
  - load during EXPIRED: IDLE, alarm=0, preset captured.
- done is never asserted except on the countdown-to-zero edge. Loading 00:00 does not pulse done.
- Internal alarm counters are sized from the parameters (clog2). No combinational path from inputs to outputs.

Test Plan:
- Reset asserted mid-RUNNING at 12:34 -> all outputs 0 asynchronously, state IDLE; after release, start is ignored (count 00:00).
- load with preset 00:05, then start -> outputs 00:04, 00:03, 00:02, 00:01, 00:00 on successive cycles; done high exactly one cycle with 00:00; running falls with done; alarm high.
- load 01:00, start, run 1 cycle -> 00:99 (all borrows). load 10:00, start, 1 cycle -> 09:99.
- load preset digits F,F,F,F -> count reads 59:99. load preset 7,3,A,2 -> 53:92.
- Mid-count pause at 00:50 -> holds 00:50 for 20 cycles with running=0; start -> next cycle 00:49. Simultaneous start+pause -> no change.
- After expiry with defaults:
  - alarm pattern is 25 high / 25 low, returning to IDLE with alarm=0 after 300 cycles.
  - Repeat run, pulse start at cycle 40 of the alarm -> alarm=0 next cycle, IDLE.
  - Repeat run, pulse load at cycle 40 with preset 00:10 -> reads 00:10, IDLE, no done.
